// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the CPU-side memory access sequencer: FSM state
// encoding and the memory map bank bases used by the CPU and benches.
package mem_access_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [15:0] BANK_RAM    = 16'h0000;
  localparam logic [15:0] BANK_ROM    = 16'h4000;
  localparam logic [15:0] BANK_PERIPH = 16'h8000;
  localparam logic [15:0] BANK_BRAM   = 16'hC000;

endpackage

// File: rtl/mem_access_sequencer.sv
// Splits CPU byte/word loads and stores into little-endian byte accesses on
// the 8-bit memory bus, waiting out the bank read latency for each byte.
module mem_access_sequencer
  import mem_access_sequencer_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic        word,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        done,
  output logic        busy,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_in,
  input  logic [7:0]  bus_data_out,
  output logic        bus_enable,
  output logic        bus_write_enable
);

  localparam logic [1:0] LAST_WAIT = 2'(READ_LATENCY);

  state_t      state;
  logic        lat_wr;
  logic        lat_word;
  logic [15:0] lat_addr;
  logic [15:0] lat_wdata;
  logic        byte_idx;
  logic [1:0]  wait_cnt;

  // All bus-facing outputs are registered here; the first byte's bus
  // signals are loaded on the accepting edge so ACCESS starts driving at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      lat_wr           <= 1'b0;
      lat_word         <= 1'b0;
      lat_addr         <= 16'h0000;
      lat_wdata        <= 16'h0000;
      byte_idx         <= 1'b0;
      wait_cnt         <= 2'd0;
      rdata            <= 16'h0000;
      done             <= 1'b0;
      busy             <= 1'b0;
      bus_address      <= 16'h0000;
      bus_data_in      <= 8'h00;
      bus_enable       <= 1'b0;
      bus_write_enable <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          done             <= 1'b0;
          busy             <= 1'b0;
          bus_enable       <= 1'b0;
          bus_write_enable <= 1'b0;
          if (req) begin
            lat_wr           <= wr;
            lat_word         <= word;
            lat_addr         <= addr;
            lat_wdata        <= wdata;
            byte_idx         <= 1'b0;
            wait_cnt         <= 2'd0;
            bus_address      <= addr;
            bus_data_in      <= wdata[7:0];
            bus_enable       <= 1'b1;
            bus_write_enable <= wr;
            busy             <= 1'b1;
            if (!wr && !word) begin
              rdata[15:8] <= 8'h00;
            end
            state <= ST_ACCESS;
          end
        end

        ST_ACCESS: begin
          // Stores finish a byte every cycle; loads hold the address until
          // the wait counter reaches the read latency, then capture.
          if (lat_wr || wait_cnt == LAST_WAIT) begin
            if (!lat_wr) begin
              if (byte_idx) begin
                rdata[15:8] <= bus_data_out;
              end else begin
                rdata[7:0] <= bus_data_out;
              end
            end
            wait_cnt <= 2'd0;
            if (lat_word && !byte_idx) begin
              byte_idx    <= 1'b1;
              bus_address <= lat_addr + 16'd1;
              bus_data_in <= lat_wdata[15:8];
            end else begin
              bus_enable       <= 1'b0;
              bus_write_enable <= 1'b0;
              done             <= 1'b1;
              state            <= ST_DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer against a behavioural byte memory
// with a READ_LATENCY-deep read pipeline.
module tb_mem_access_sequencer;
  import mem_access_sequencer_pkg::*;

  localparam int READ_LATENCY = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic        word = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        done;
  logic        busy;
  logic [15:0] bus_address;
  logic [7:0]  bus_data_in;
  logic [7:0]  bus_data_out;
  logic        bus_enable;
  logic        bus_write_enable;

  mem_access_sequencer #(.READ_LATENCY(READ_LATENCY)) dut (
    .clk              (clk),
    .reset            (reset),
    .req              (req),
    .wr               (wr),
    .word             (word),
    .addr             (addr),
    .wdata            (wdata),
    .rdata            (rdata),
    .done             (done),
    .busy             (busy),
    .bus_address      (bus_address),
    .bus_data_in      (bus_data_in),
    .bus_data_out     (bus_data_out),
    .bus_enable       (bus_enable),
    .bus_write_enable (bus_write_enable)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [65536] = '{default: 8'h00};
  logic [7:0]  pipe [READ_LATENCY];
  int          cyc = 0;
  int          en_cnt = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          log_n = 0;
  logic [15:0] log_addr [64];
  logic [7:0]  log_data [64];
  int          log_cyc [64];

  assign bus_data_out = pipe[READ_LATENCY-1];

  // Byte memory with synchronous read latency, plus a bus activity log.
  always @(posedge clk) begin
    cyc = cyc + 1;
    pipe[0] <= mem[bus_address];
    for (int k = 1; k < READ_LATENCY; k++) pipe[k] <= pipe[k-1];
    if (bus_enable) en_cnt = en_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (bus_enable && bus_write_enable) begin
      mem[bus_address] <= bus_data_in;
      wr_cnt = wr_cnt + 1;
      if (log_n < 64) begin
        log_addr[log_n] = bus_address;
        log_data[log_n] = bus_data_in;
        log_cyc[log_n]  = cyc;
      end
      log_n = log_n + 1;
    end
  end

  typedef struct {
    logic        wr;
    logic        word;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_edges;
    logic [15:0] exp_rdata;
    int          exp_en;
    int          exp_writes;
  } vec_t;

  vec_t vectors [12];
  int   vectors_applied = 0;
  int   miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int n;
    int en0;
    int wr0;
    int log0;
    logic [15:0] hi_addr;
    en0 = en_cnt;
    wr0 = wr_cnt;
    log0 = log_n;
    req = 1'b1;
    wr = v.wr;
    word = v.word;
    addr = v.addr;
    wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({tag, "_latency"}, 32'(n), 32'(v.exp_edges));
    checkOutput({tag, "_rdata"}, {16'h0, rdata}, {16'h0, v.exp_rdata});
    checkOutput({tag, "_enable_cycles"}, 32'(en_cnt - en0), 32'(v.exp_en));
    checkOutput({tag, "_writes"}, 32'(wr_cnt - wr0), 32'(v.exp_writes));
    if (v.wr && v.word && log0 + 1 < 64) begin
      hi_addr = v.addr + 16'd1;
      checkOutput({tag, "_lo_byte"}, {8'h0, log_addr[log0], log_data[log0]}, {8'h0, v.addr, v.wdata[7:0]});
      checkOutput({tag, "_hi_byte"}, {8'h0, log_addr[log0+1], log_data[log0+1]}, {8'h0, hi_addr, v.wdata[15:8]});
      checkOutput({tag, "_consecutive"}, 32'(log_cyc[log0+1] - log_cyc[log0]), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic w, input logic wd, input logic [15:0] a, input logic [15:0] d,
                              input int edges, input logic [15:0] r);
    vec_t v;
    int nbytes;
    nbytes = wd ? 2 : 1;
    v.wr = w;
    v.word = wd;
    v.addr = a;
    v.wdata = d;
    v.exp_edges = edges;
    v.exp_rdata = r;
    v.exp_en = w ? nbytes : nbytes * (READ_LATENCY + 1);
    v.exp_writes = w ? nbytes : 0;
    return v;
  endfunction

  initial begin
    int n;
    int d0;
    int w0;
    vec_t v;

    vectors[0]  = mk(1'b1, 1'b1, 16'h0010, 16'hBEEF, 2, 16'h0000);
    vectors[1]  = mk(1'b1, 1'b1, 16'h0020, 16'h1234, 2, 16'h0000);
    vectors[2]  = mk(1'b0, 1'b1, 16'h0020, 16'h0000, 4, 16'h1234);
    vectors[3]  = mk(1'b0, 1'b0, 16'h0011, 16'h0000, 2, 16'h00BE);
    vectors[4]  = mk(1'b1, 1'b1, 16'hFFFF, 16'hA55A, 2, 16'h00BE);
    vectors[5]  = mk(1'b0, 1'b1, 16'hFFFF, 16'h0000, 4, 16'hA55A);
    vectors[6]  = mk(1'b0, 1'b0, 16'h0000, 16'h0000, 2, 16'h00A5);
    vectors[7]  = mk(1'b1, 1'b0, BANK_ROM - 16'd1, 16'h1277, 1, 16'h00A5);
    vectors[8]  = mk(1'b1, 1'b0, BANK_ROM, 16'h0088, 1, 16'h00A5);
    vectors[9]  = mk(1'b0, 1'b1, BANK_ROM - 16'd1, 16'h0000, 4, 16'h8877);
    vectors[10] = mk(1'b1, 1'b0, 16'h0010, 16'hFF11, 1, 16'h8877);
    vectors[11] = mk(1'b0, 1'b1, 16'h0010, 16'h0000, 4, 16'hBE11);

    #12;
    checkOutput("reset_outputs", {rdata, 7'h0, done, busy, bus_enable, bus_write_enable, bus_data_in},
                32'h0);
    checkOutput("reset_address", {16'h0, bus_address}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vectors[i], $sformatf("vec%0d", i));
    end

    // Requests during ACCESS and during DONE must be dropped.
    d0 = done_cnt;
    w0 = wr_cnt;
    req = 1'b1; wr = 1'b0; word = 1'b1; addr = 16'h0010; wdata = 16'h0000;
    @(posedge clk); #1;
    wr = 1'b1; word = 1'b0; addr = 16'h0500; wdata = 16'h00AA;
    @(posedge clk); #1;
    req = 1'b0;
    n = 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("ignore_latency", 32'(n), 32'd4);
    checkOutput("ignore_rdata", {16'h0, rdata}, 32'h0000BE11);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    checkOutput("ignore_busy_after", {31'h0, busy}, 32'h0);
    @(posedge clk); #1;
    checkOutput("ignore_busy_later", {31'h0, busy}, 32'h0);
    checkOutput("ignore_writes", 32'(wr_cnt - w0), 32'h0);
    checkOutput("ignore_done_count", 32'(done_cnt - d0), 32'd1);
    checkOutput("ignore_mem", {24'h0, mem[16'h0500]}, 32'h0);

    // req held high: back-to-back transfers with a single IDLE cycle between.
    w0 = wr_cnt;
    req = 1'b1; wr = 1'b1; word = 1'b0; addr = 16'h0100; wdata = 16'h005C;
    @(posedge clk); #1;
    checkOutput("held_busy_access", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    checkOutput("held_done", {30'h0, done, busy}, 32'h3);
    @(posedge clk); #1;
    checkOutput("held_idle_gap", {30'h0, done, busy}, 32'h0);
    @(posedge clk); #1;
    checkOutput("held_second_accept", {31'h0, busy}, 32'h1);
    req = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("held_second_latency", 32'(n), 32'd1);
    @(posedge clk); #1;
    checkOutput("held_writes", 32'(wr_cnt - w0), 32'd2);
    checkOutput("held_mem", {24'h0, mem[16'h0100]}, 32'h5C);

    // Asynchronous reset during the second byte of a word store.
    d0 = done_cnt;
    req = 1'b1; wr = 1'b1; word = 1'b1; addr = 16'h0200; wdata = 16'h3344;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_pre_we", {31'h0, bus_write_enable}, 32'h1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_async_outputs", {29'h0, bus_write_enable, bus_enable, busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_no_done", 32'(done_cnt - d0), 32'h0);
    checkOutput("rst_busy", {31'h0, busy}, 32'h0);
    checkOutput("rst_hi_byte_unwritten", {24'h0, mem[16'h0201]}, 32'h0);
    v = mk(1'b0, 1'b1, 16'h0200, 16'h0000, 4, 16'h0044);
    applyStimulus(v, "rst_reload");

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sits between the CPU core and memory_bus; the CPU issues byte or 16-bit word loads/stores through it.
- Splits each word access into two little-endian byte accesses on the 8-bit memory bus: low byte at addr, high byte at addr+1.
- Inserts wait cycles for the synchronous read latency of the ROM/RAM/peripheral banks.
- Returns a one-cycle done pulse with assembled read data, freeing the CPU from byte sequencing and bank timing.

Parameters:
- READ_LATENCY, 1, clock cycles between a stable bus_address and valid bus_data_out (range 1-3).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  CPU access request; sampled only in IDLE.
- wr  input  1  1 = store, 0 = load; latched with req.
- word  input  1  1 = 16-bit access, 0 = byte access; latched with req.
- addr  input  16  CPU byte address; latched with req.
- wdata  input  16  store data; byte stores use wdata[7:0]; latched with req.
- rdata  output  16  load result; byte loads zero-extend.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high whenever state != IDLE.
- bus_address  output  16  to memory_bus address.
- bus_data_in  output  8  to memory_bus data_in.
- bus_data_out  input  8  from memory_bus data_out.
- bus_enable  output  1  to memory_bus bus_enable.
- bus_write_enable  output  1  to memory_bus write_enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - rdata=0, done=0, busy=0, bus_address=0, bus_data_in=0, bus_enable=0, bus_write_enable=0.
  - Latched request and wait counter are cleared.
  - Reset mid-transfer aborts the transfer with no done pulse; bus_write_enable drops immediately.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - bus_enable=0, bus_write_enable=0.
  - On req=1, latch wr/word/addr/wdata, set byte index=0, clear wait counter, and go to ACCESS.
- ACCESS, write:
  - bus_address = latched addr + index, 16-bit wrap, so 0xFFFF+1 = 0x0000.
  - bus_data_in = wdata byte[index].
  - bus_enable=1 and bus_write_enable=1 for exactly one cycle per byte.
  - Then go to the next byte, or to DONE after the last byte.
- ACCESS, read:
  - bus_address is held stable and bus_enable=1 for READ_LATENCY+1 cycles; bus_write_enable=0.
  - bus_data_out is captured into rdata byte[index] on the final edge of that window.
  - The wait counter counts 0..READ_LATENCY.
  - The next byte restarts the counter.
- Byte loads clear rdata[15:8] when the request is accepted.
- DONE:
  - done=1 for exactly one cycle, busy=1, bus_enable=0; then return to IDLE.
  - rdata is valid from the DONE cycle and held until the next load is accepted.
  - Stores leave rdata unchanged.
- Latency from the accepting edge to done high, as cycle counts:
  - byte store: 1 access cycle + DONE.
  - word store: 2 + DONE.
  - byte load: (READ_LATENCY+1) + DONE.
  - word load: 2*(READ_LATENCY+1) + DONE.
- Handshake:
  - req while busy=1, including the DONE cycle, is ignored; there is no queueing.
  - The CPU holds req until it sees busy or done, or pulses req only when busy=0.
  - req held high continuously produces back-to-back transfers separated by one IDLE cycle.
- Odd addresses are legal; there is no alignment penalty beyond the normal two byte accesses.
- A word access crossing a bank boundary (e.g. 0x3FFF→0x4000) is two independent bytes routed by memory_bus; no special handling.
- Outputs are registered; no combinational path from req to bus outputs.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_ACCESS, ST_DONE.
  - bank base constants BANK_RAM=0x0000, BANK_ROM=0x4000, BANK_PERIPH=0x8000, BANK_BRAM=0xC000, used by benches and the CPU.
- No sub-module is needed; the wait counter is inline.
- The bench instantiates mem_access_sequencer with memory_bus, or with a behavioural byte memory modelling READ_LATENCY.

Test Plan:
- Word store addr=0x0010, wdata=0xBEEF → bus writes 0xEF@0x0010 then 0xBE@0x0011 on consecutive cycles; done high 3 cycles after the accepting edge.
- Word load addr=0x0010 after that store, READ_LATENCY=1 → rdata=0xBEEF; done exactly 5 cycles after acceptance; bus_address stable 2 cycles per byte.
- Byte load addr=0x0011 with prior rdata=0x1234 → rdata=0x00BE; one bus read only.
- Word store addr=0xFFFF, wdata=0xA55A → 0x5A@0xFFFF, 0xA5@0x0000 (wrap); a word load back returns 0xA55A.
- req pulsed again during ACCESS and DONE → ignored, no second transfer; req held high → second transfer starts after one IDLE cycle.
- reset driven low mid word store after the first byte → bus_write_enable drops asynchronously, no done, second byte never written; after release busy=0 and a new req works normally.
